// File: rtl/adc_stream_unpacker_pkg.sv
// Shared constants for the ADC stream unpacker: packed-word field layout,
// trigger-location encoding and the emit FSM state encoding.
package adc_stream_unpacker_pkg;

   localparam int SAMPLE_W       = 10;
   localparam int S0_LSB         = 0;
   localparam int S1_LSB         = 10;
   localparam int S2_LSB         = 20;
   localparam int LOC_LSB        = 30;
   localparam int BYTES_PER_WORD = 4;

   // A location of 2'b11 means the capture had not triggered yet when the word was packed
   localparam logic [1:0] TRIG_NONE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EMIT0,
      ST_EMIT1,
      ST_EMIT2,
      ST_DONE
   } state_t;

   function automatic logic [SAMPLE_W-1:0] pickSample(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    return word[S0_LSB +: SAMPLE_W];
         2'd1:    return word[S1_LSB +: SAMPLE_W];
         2'd2:    return word[S2_LSB +: SAMPLE_W];
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/adc_byte_assembler.sv
// Issues byte reads to the capture FIFO and assembles four returned bytes,
// MSB byte first, into one 32-bit word offered on a valid/take handshake.
module adc_byte_assembler
   import adc_stream_unpacker_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic        i_fifoEmpty,
   input  logic [7:0]  i_fifoData,
   input  logic        i_wordTake,
   output logic        o_fifoEn,
   output logic        o_wordValid,
   output logic [31:0] o_word
);

   logic [2:0]  r_issued;
   logic [1:0]  r_captured;
   logic        r_pending;
   logic [23:0] r_shift;
   logic        w_issue;

   assign w_issue     = i_enable && !i_fifoEmpty && (r_issued < 3'(BYTES_PER_WORD));
   assign o_fifoEn    = w_issue;
   // The fourth byte is used straight off the read port so the word is ready one cycle after its strobe
   assign o_wordValid = r_pending && (r_captured == 2'd3);
   assign o_word      = {r_shift, i_fifoData};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_issued   <= '0;
         r_captured <= '0;
         r_pending  <= 1'b0;
         r_shift    <= '0;
      end else begin
         r_pending <= w_issue;
         if (o_wordValid && i_wordTake) begin
            r_issued   <= '0;
            r_captured <= '0;
         end else begin
            if (w_issue) begin
               r_issued <= r_issued + 3'd1;
            end
            if (r_pending) begin
               r_shift    <= {r_shift[15:0], i_fifoData};
               r_captured <= r_captured + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/adc_stream_unpacker.sv
// Read-side unpacker for the ADC capture FIFO: turns each 32-bit packed word into
// three 10-bit samples in capture order and flags the trigger sample.
module adc_stream_unpacker
   import adc_stream_unpacker_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 fifo_read_fifoclk,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] num_samples_i,
   output logic                 fifo_read_fifoen,
   input  logic                 fifo_read_fifoempty,
   input  logic [7:0]           fifo_read_data,
   output logic [SAMPLE_W-1:0]  sample_o,
   output logic                 sample_valid_o,
   input  logic                 sample_ready_i,
   output logic                 sample_trig_o,
   output logic [CNT_WIDTH-1:0] samples_done_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 proto_err_o
);

   state_t               r_state, w_nextState;
   logic [31:0]          r_word;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_done, r_protoErr, r_trigSeen, r_markWord;
   logic [1:0]           r_trigLoc;

   logic                 w_fetching, w_wordValid, w_emitting, w_accept, w_limitHit, w_start;
   logic [31:0]          w_word;
   logic [1:0]           w_idx, w_loc;
   logic [CNT_WIDTH-1:0] w_countNext;

   // Gating with reset keeps a strobe from escaping in the cycle a transfer is aborted
   assign w_fetching = (r_state == ST_FETCH) && !reset_i;

   adc_byte_assembler u_assembler (
      .clk         (fifo_read_fifoclk),
      .reset       (reset_i),
      .i_enable    (w_fetching),
      .i_fifoEmpty (fifo_read_fifoempty),
      .i_fifoData  (fifo_read_data),
      .i_wordTake  (r_state == ST_FETCH),
      .o_fifoEn    (fifo_read_fifoen),
      .o_wordValid (w_wordValid),
      .o_word      (w_word)
   );

   assign w_accept    = w_emitting && sample_ready_i;
   assign w_countNext = (r_count == '1) ? r_count : r_count + 1'b1;
   assign w_limitHit  = (num_samples_i != '0) && (w_countNext == num_samples_i);
   assign w_start     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_loc       = w_word[LOC_LSB +: 2];

   always_comb begin
      w_nextState = r_state;
      w_emitting  = 1'b0;
      w_idx       = 2'd0;
      case (r_state)
         ST_IDLE, ST_DONE: if (start_i) w_nextState = ST_FETCH;
         ST_FETCH: if (w_wordValid) w_nextState = ST_EMIT0;
         ST_EMIT0: begin
            w_emitting = 1'b1;
            w_idx      = 2'd0;
            if (w_accept) w_nextState = w_limitHit ? ST_DONE : ST_EMIT1;
         end
         ST_EMIT1: begin
            w_emitting = 1'b1;
            w_idx      = 2'd1;
            if (w_accept) w_nextState = w_limitHit ? ST_DONE : ST_EMIT2;
         end
         ST_EMIT2: begin
            w_emitting = 1'b1;
            w_idx      = 2'd2;
            if (w_accept) w_nextState = w_limitHit ? ST_DONE : ST_FETCH;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   assign sample_valid_o = w_emitting;
   assign sample_o       = w_emitting ? pickSample(r_word, w_idx) : '0;
   assign sample_trig_o  = w_emitting && r_markWord && (w_idx == r_trigLoc);
   assign samples_done_o = r_count;
   assign busy_o         = (r_state == ST_FETCH) || (r_state == ST_EMIT0) ||
                           (r_state == ST_EMIT1) || (r_state == ST_EMIT2);
   assign done_o         = r_done;
   assign proto_err_o    = r_protoErr;

   // Only the first triggered word is marked; later words must repeat the same location
   always_ff @(posedge fifo_read_fifoclk) begin
      if (reset_i) begin
         r_state    <= ST_IDLE;
         r_word     <= '0;
         r_count    <= '0;
         r_done     <= 1'b0;
         r_protoErr <= 1'b0;
         r_trigSeen <= 1'b0;
         r_trigLoc  <= '0;
         r_markWord <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_start) begin
            r_count    <= '0;
            r_done     <= 1'b0;
            r_protoErr <= 1'b0;
            r_trigSeen <= 1'b0;
            r_markWord <= 1'b0;
         end
         if (w_accept) begin
            r_count <= w_countNext;
            if (w_limitHit) r_done <= 1'b1;
         end
         if ((r_state == ST_FETCH) && w_wordValid) begin
            r_word     <= w_word;
            r_markWord <= 1'b0;
            if (r_trigSeen) begin
               if (w_loc != r_trigLoc) r_protoErr <= 1'b1;
            end else if (w_loc != TRIG_NONE) begin
               r_trigSeen <= 1'b1;
               r_trigLoc  <= w_loc;
               r_markWord <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_stream_unpacker.sv
// Randomized bench for adc_stream_unpacker: a FIFO model feeds bytes and a
// word-level reference model predicts the sample/trigger stream and status.
module tb_adc_stream_unpacker;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] num_samples_i = '0;
   logic        fifo_read_fifoen;
   logic        fifo_read_fifoempty = 1'b1;
   logic [7:0]  fifo_read_data = '0;
   logic [9:0]  sample_o;
   logic        sample_valid_o;
   logic        sample_ready_i = 1'b0;
   logic        sample_trig_o;
   logic [31:0] samples_done_o;
   logic        busy_o, done_o, proto_err_o;

   adc_stream_unpacker #(.CNT_WIDTH(32)) dut (
      .fifo_read_fifoclk   (clk),
      .reset_i             (reset_i),
      .start_i             (start_i),
      .num_samples_i       (num_samples_i),
      .fifo_read_fifoen    (fifo_read_fifoen),
      .fifo_read_fifoempty (fifo_read_fifoempty),
      .fifo_read_data      (fifo_read_data),
      .sample_o            (sample_o),
      .sample_valid_o      (sample_valid_o),
      .sample_ready_i      (sample_ready_i),
      .sample_trig_o       (sample_trig_o),
      .samples_done_o      (samples_done_o),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .proto_err_o         (proto_err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cycleNo = 0;
   int strobeCnt = 0;
   int acceptCnt = 0;
   int stallLeft = 0;
   bit strobed = 1'b0;
   bit prevHold = 1'b0;
   logic [7:0] pendByte = '0;
   logic [9:0] prevSample = '0;

   logic [7:0] fifoQ[$];
   logic [9:0] expSample[$];
   logic       expTrig[$];
   bit         mTrigSeen;
   bit         mErr;
   logic [1:0] mLoc;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycleNo);
      end
   endtask

   // Reference model: a word becomes four bytes in the FIFO and three expected samples
   task automatic loadWord(input logic [31:0] w);
      logic [1:0] loc;
      bit         mark;
      loc  = w[31:30];
      mark = 1'b0;
      fifoQ.push_back(w[31:24]);
      fifoQ.push_back(w[23:16]);
      fifoQ.push_back(w[15:8]);
      fifoQ.push_back(w[7:0]);
      if (mTrigSeen) begin
         if (loc != mLoc) mErr = 1'b1;
      end else if (loc != 2'b11) begin
         mTrigSeen = 1'b1;
         mLoc      = loc;
         mark      = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         expSample.push_back(w[i*10 +: 10]);
         expTrig.push_back(mark && (int'(loc) == i));
      end
   endtask

   task automatic newTransfer();
      mTrigSeen = 1'b0;
      mErr      = 1'b0;
      mLoc      = 2'b00;
      fifoQ.delete();
      expSample.delete();
      expTrig.delete();
      strobeCnt = 0;
      acceptCnt = 0;
   endtask

   // emptyMode: 0 never, 1 every other cycle, 2 random, 3 after two strobes
   // readyMode: 0 always, 1 random, 2 stall 20 cycles after first accept, 3 never
   task automatic applyStimulus(input bit st, input int emptyMode, input int readyMode);
      bit forced;
      @(posedge clk);
      #1;
      cycleNo++;
      fifo_read_data = strobed ? pendByte : 8'($urandom);
      strobed = 1'b0;
      start_i = st;
      case (emptyMode)
         1:       forced = cycleNo[0];
         2:       forced = ($urandom_range(0, 1) == 0);
         3:       forced = (strobeCnt >= 2);
         default: forced = 1'b0;
      endcase
      fifo_read_fifoempty = (fifoQ.size() == 0) || forced;
      case (readyMode)
         1:       sample_ready_i = ($urandom_range(0, 1) == 1);
         3:       sample_ready_i = 1'b0;
         default: sample_ready_i = (stallLeft == 0);
      endcase
      if (stallLeft > 0) stallLeft--;
      @(negedge clk);
      checkOutput("enWhileEmpty", fifo_read_fifoen & fifo_read_fifoempty, 0);
      if (fifo_read_fifoen && !fifo_read_fifoempty) begin
         strobeCnt++;
         pendByte = fifoQ.pop_front();
         strobed  = 1'b1;
      end
      if (prevHold) begin
         checkOutput("holdValid", sample_valid_o, 1);
         checkOutput("holdSample", sample_o, prevSample);
      end
      if (sample_valid_o && sample_ready_i) begin
         checkOutput("samplePending", expSample.size() > 0, 1);
         if (expSample.size() > 0) begin
            checkOutput("sample", sample_o, expSample.pop_front());
            checkOutput("trig", sample_trig_o, expTrig.pop_front());
         end
         acceptCnt++;
         if (readyMode == 2 && acceptCnt == 1) stallLeft = 20;
      end
      prevHold   = sample_valid_o && !sample_ready_i;
      prevSample = sample_o;
   endtask

   task automatic startTransfer(input logic [31:0] num, input int emptyMode, input int readyMode);
      num_samples_i = num;
      applyStimulus(1'b1, emptyMode, readyMode);
   endtask

   task automatic runUntil(input int target, input int emptyMode, input int readyMode, input int maxCycles);
      int n = 0;
      while (acceptCnt < target && n < maxCycles) begin
         applyStimulus(1'b0, emptyMode, readyMode);
         n++;
      end
      checkOutput("timeout", acceptCnt >= target, 1);
   endtask

   task automatic finishLimited(input int limit, input int words);
      applyStimulus(1'b0, 0, 0);
      checkOutput("doneFlag", done_o, 1);
      checkOutput("samplesDone", samples_done_o, limit);
      checkOutput("busyAfterDone", busy_o, 0);
      checkOutput("validAfterDone", sample_valid_o, 0);
      checkOutput("strobeCount", strobeCnt, 4 * words);
      checkOutput("protoErr", proto_err_o, mErr);
      checkOutput("leftover", expSample.size(), 0);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      start_i = 1'b0;
      fifo_read_fifoempty = 1'b1;
      @(posedge clk);
      #1;
      reset_i   = 1'b0;
      strobed   = 1'b0;
      prevHold  = 1'b0;
      stallLeft = 0;
      @(negedge clk);
      checkOutput("rstSample", sample_o, 0);
      checkOutput("rstValid", sample_valid_o, 0);
      checkOutput("rstTrig", sample_trig_o, 0);
      checkOutput("rstCount", samples_done_o, 0);
      checkOutput("rstBusy", busy_o, 0);
      checkOutput("rstDone", done_o, 0);
      checkOutput("rstErr", proto_err_o, 0);
      checkOutput("rstFifoEn", fifo_read_fifoen, 0);
   endtask

   initial begin
      int n;
      logic [1:0] locs[5];
      locs = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b01};

      doReset();

      $display("[TB] single known word, limit 3");
      newTransfer();
      loadWord(32'h40302010);
      startTransfer(3, 0, 0);
      runUntil(3, 0, 0, 200);
      finishLimited(3, 1);

      $display("[TB] empty toggling, 4 words, random ready");
      newTransfer();
      for (int i = 0; i < 4; i++) loadWord($urandom);
      startTransfer(12, 1, 1);
      runUntil(12, 1, 1, 1000);
      finishLimited(12, 4);

      $display("[TB] consumer stall in EMIT1");
      newTransfer();
      loadWord($urandom);
      startTransfer(3, 0, 2);
      runUntil(3, 0, 2, 300);
      finishLimited(3, 1);

      $display("[TB] trigger location sequence");
      newTransfer();
      for (int i = 0; i < 5; i++) loadWord({locs[i], 30'($urandom)});
      startTransfer(15, 2, 1);
      runUntil(15, 2, 1, 2000);
      finishLimited(15, 5);

      $display("[TB] reset after two bytes");
      newTransfer();
      loadWord($urandom);
      startTransfer(3, 3, 0);
      n = 0;
      while (!(strobeCnt >= 2 && !strobed) && n < 50) begin
         applyStimulus(1'b0, 3, 0);
         n++;
      end
      checkOutput("twoStrobes", strobeCnt, 2);
      doReset();
      newTransfer();
      loadWord($urandom);
      loadWord($urandom);
      startTransfer(6, 0, 0);
      runUntil(6, 0, 0, 300);
      finishLimited(6, 2);

      $display("[TB] unlimited run with start while busy");
      newTransfer();
      for (int i = 0; i < 110; i++) loadWord($urandom);
      startTransfer(0, 2, 1);
      runUntil(150, 2, 1, 4000);
      applyStimulus(1'b1, 2, 1);
      runUntil(300, 2, 1, 4000);
      applyStimulus(1'b0, 2, 3);
      checkOutput("unlimCount", samples_done_o, acceptCnt);
      checkOutput("unlimAccepted", acceptCnt, 300);
      checkOutput("unlimDone", done_o, 0);
      checkOutput("unlimBusy", busy_o, 1);
      doReset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
